// File: rtl/cmd_issue_generator.sv
// Command codes shared with the scheduler, plus the producer that expands host
// requests and periodic refresh into PRECHARGE/ACTIVE/READ/WRITE/REFRESH pushes.
package command_definition_pkg;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_ACTIVE    = 3'd1,
        CMD_READ      = 3'd2,
        CMD_WRITE     = 3'd3,
        CMD_PRECHARGE = 3'd4,
        CMD_REFRESH   = 3'd5
    } command_t;

endpackage

module cmd_issue_generator
    import command_definition_pkg::*;
#(
    parameter int NUM_BANKS        = 8,
    parameter int ROW_BITS         = 14,
    parameter int COL_BITS         = 10,
    parameter int REFRESH_INTERVAL = 1560,
    localparam int BA_BITS         = $clog2(NUM_BANKS)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_write,
    input  logic [BA_BITS-1:0]  i_req_bank,
    input  logic [ROW_BITS-1:0] i_req_row,
    input  logic [COL_BITS-1:0] i_req_col,

    output logic                o_issue_wen,
    input  logic                i_issue_queue_full,
    output command_t            o_issue_cmd,
    output logic [BA_BITS-1:0]  o_issue_bank,
    output logic [ROW_BITS-1:0] o_issue_row,
    output logic [COL_BITS-1:0] o_issue_col,

    output logic                o_busy
);

    localparam int REF_W = $clog2(REFRESH_INTERVAL + 1);
    localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REFRESH_INTERVAL - 1);
    localparam logic [BA_BITS:0] LAST_BANK  = (BA_BITS + 1)'(NUM_BANKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_PRE,
        ISSUE_ACT,
        ISSUE_RW,
        REF_PRE,
        REF_CMD
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_BANKS-1:0] bankOpen_q, bankOpen_d;
    logic [ROW_BITS-1:0]  rowTable_q [NUM_BANKS];
    logic [ROW_BITS-1:0]  rowTable_d [NUM_BANKS];
    logic [REF_W-1:0]     refCnt_q, refCnt_d;
    logic                 refPending_q, refPending_d;
    logic [BA_BITS:0]     scanIdx_q, scanIdx_d;

    logic                 reqWrite_q, reqWrite_d;
    logic [BA_BITS-1:0]   reqBank_q, reqBank_d;
    logic [ROW_BITS-1:0]  reqRow_q, reqRow_d;
    logic [COL_BITS-1:0]  reqCol_q, reqCol_d;

    logic [BA_BITS-1:0]   scanBank;
    logic                 scanBankOpen;
    logic                 emit;
    logic                 push;
    logic                 refExpire;

    assign scanBank     = scanIdx_q[BA_BITS-1:0];
    assign scanBankOpen = bankOpen_q[scanBank];
    assign refExpire    = (refCnt_q == '0);

    assign o_req_ready  = (state_q == IDLE) && !refPending_q && !rst;
    assign o_busy       = (state_q != IDLE);
    assign push         = emit && !i_issue_queue_full && !rst;
    assign o_issue_wen  = push;

    // Command fields come only from registered state, so they hold steady while the FIFO stalls us.
    always_comb begin
        emit         = 1'b0;
        o_issue_cmd  = CMD_NOP;
        o_issue_bank = '0;
        o_issue_row  = '0;
        o_issue_col  = '0;
        case (state_q)
            ISSUE_PRE: begin
                emit         = 1'b1;
                o_issue_cmd  = CMD_PRECHARGE;
                o_issue_bank = reqBank_q;
            end
            ISSUE_ACT: begin
                emit         = 1'b1;
                o_issue_cmd  = CMD_ACTIVE;
                o_issue_bank = reqBank_q;
                o_issue_row  = reqRow_q;
            end
            ISSUE_RW: begin
                emit         = 1'b1;
                o_issue_cmd  = reqWrite_q ? CMD_WRITE : CMD_READ;
                o_issue_bank = reqBank_q;
                o_issue_col  = reqCol_q;
            end
            REF_PRE: begin
                emit         = scanBankOpen;
                o_issue_cmd  = CMD_PRECHARGE;
                o_issue_bank = scanBank;
            end
            REF_CMD: begin
                emit         = 1'b1;
                o_issue_cmd  = CMD_REFRESH;
            end
            default: begin
                emit         = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        bankOpen_d   = bankOpen_q;
        rowTable_d   = rowTable_q;
        scanIdx_d    = scanIdx_q;
        reqWrite_d   = reqWrite_q;
        reqBank_d    = reqBank_q;
        reqRow_d     = reqRow_q;
        reqCol_d     = reqCol_q;
        refCnt_d     = refExpire ? REF_RELOAD : (refCnt_q - REF_W'(1));
        refPending_d = refPending_q;

        case (state_q)
            IDLE: begin
                if (refPending_q) begin
                    state_d   = REF_PRE;
                    scanIdx_d = '0;
                end else if (i_req_valid && o_req_ready) begin
                    reqWrite_d = i_req_write;
                    reqBank_d  = i_req_bank;
                    reqRow_d   = i_req_row;
                    reqCol_d   = i_req_col;
                    if (!bankOpen_q[i_req_bank]) begin
                        state_d = ISSUE_ACT;
                    end else if (rowTable_q[i_req_bank] == i_req_row) begin
                        state_d = ISSUE_RW;
                    end else begin
                        state_d = ISSUE_PRE;
                    end
                end
            end
            ISSUE_PRE: begin
                if (push) begin
                    bankOpen_d[reqBank_q] = 1'b0;
                    state_d               = ISSUE_ACT;
                end
            end
            ISSUE_ACT: begin
                if (push) begin
                    bankOpen_d[reqBank_q] = 1'b1;
                    rowTable_d[reqBank_q] = reqRow_q;
                    state_d               = ISSUE_RW;
                end
            end
            ISSUE_RW: begin
                if (push) begin
                    state_d = IDLE;
                end
            end
            REF_PRE: begin
                // Closed banks cost a scan cycle but never wait on the FIFO.
                if (push || !scanBankOpen) begin
                    bankOpen_d[scanBank] = 1'b0;
                    scanIdx_d            = scanIdx_q + (BA_BITS + 1)'(1);
                    if (scanIdx_q == LAST_BANK) begin
                        state_d = REF_CMD;
                    end
                end
            end
            REF_CMD: begin
                if (push) begin
                    refPending_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh expiry wins over the clear so a refresh interval is never lost.
        if (refExpire) begin
            refPending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bankOpen_q   <= '0;
            rowTable_q   <= '{default: '0};
            refCnt_q     <= REF_RELOAD;
            refPending_q <= 1'b0;
            scanIdx_q    <= '0;
            reqWrite_q   <= 1'b0;
            reqBank_q    <= '0;
            reqRow_q     <= '0;
            reqCol_q     <= '0;
        end else begin
            state_q      <= state_d;
            bankOpen_q   <= bankOpen_d;
            rowTable_q   <= rowTable_d;
            refCnt_q     <= refCnt_d;
            refPending_q <= refPending_d;
            scanIdx_q    <= scanIdx_d;
            reqWrite_q   <= reqWrite_d;
            reqBank_q    <= reqBank_d;
            reqRow_q     <= reqRow_d;
            reqCol_q     <= reqCol_d;
        end
    end

endmodule

// File: tb/tb_cmd_issue_generator.sv
// Scoreboard bench: a transaction-level model queues the expected commands per
// request/refresh, and a monitor pops them whenever the DUT pushes.
module tb_cmd_issue_generator;
    import command_definition_pkg::*;

    localparam int NB = 8;
    localparam int RB = 14;
    localparam int CB = 10;
    localparam int RI = 20;
    localparam int BA = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_write;
    logic [BA-1:0] i_req_bank;
    logic [RB-1:0] i_req_row;
    logic [CB-1:0] i_req_col;
    logic          o_issue_wen;
    logic          i_issue_queue_full;
    command_t      o_issue_cmd;
    logic [BA-1:0] o_issue_bank;
    logic [RB-1:0] o_issue_row;
    logic [CB-1:0] o_issue_col;
    logic          o_busy;

    always #5 clk = ~clk;

    cmd_issue_generator #(
        .NUM_BANKS(NB), .ROW_BITS(RB), .COL_BITS(CB), .REFRESH_INTERVAL(RI)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_bank(i_req_bank),
        .i_req_row(i_req_row), .i_req_col(i_req_col),
        .o_issue_wen(o_issue_wen), .i_issue_queue_full(i_issue_queue_full),
        .o_issue_cmd(o_issue_cmd), .o_issue_bank(o_issue_bank),
        .o_issue_row(o_issue_row), .o_issue_col(o_issue_col),
        .o_busy(o_busy)
    );

    typedef struct packed {
        logic          isPush;
        command_t      cmd;
        logic [BA-1:0] bank;
        logic [RB-1:0] row;
        logic [CB-1:0] col;
    } unit_t;

    unit_t         workQ[$];
    unit_t         expQ[$];
    bit            mOpen[NB];
    logic [RB-1:0] mRow[NB];
    int            mCnt;
    bit            mPending;
    int            acceptCount = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic unit_t mkUnit(input logic isPush, input command_t c, input logic [BA-1:0] b,
                                     input logic [RB-1:0] r, input logic [CB-1:0] col);
        unit_t u;
        u.isPush = isPush;
        u.cmd    = c;
        u.bank   = b;
        u.row    = r;
        u.col    = col;
        return u;
    endfunction

    task automatic expectCmd(input unit_t u);
        workQ.push_back(u);
        if (u.isPush) expQ.push_back(u);
    endtask

    task automatic modelReset();
        workQ.delete();
        expQ.delete();
        for (int b = 0; b < NB; b++) begin
            mOpen[b] = 1'b0;
            mRow[b]  = '0;
        end
        mCnt     = RI - 1;
        mPending = 1'b0;
    endtask

    // Reference model: each cycle consumes at most one work unit; an empty work list means idle.
    always @(negedge clk) begin : modelProc
        unit_t    hd;
        command_t rw;
        bit       busyPre;
        if (rst) begin
            checkOutput("resetReady", 32'(o_req_ready), 32'd0);
            checkOutput("resetWen", 32'(o_issue_wen), 32'd0);
            modelReset();
        end else begin
            busyPre = (workQ.size() != 0);
            checkOutput("ready", 32'(o_req_ready), 32'(!busyPre && !mPending));
            checkOutput("busy", 32'(o_busy), 32'(busyPre));
            checkOutput("wenTiming", 32'(o_issue_wen),
                        32'(busyPre && workQ[0].isPush && !i_issue_queue_full));
            if (busyPre) begin
                hd = workQ[0];
                if (!hd.isPush || !i_issue_queue_full) begin
                    void'(workQ.pop_front());
                    if (hd.isPush && hd.cmd == CMD_REFRESH) mPending = 1'b0;
                end
            end else if (mPending) begin
                for (int b = 0; b < NB; b++) begin
                    expectCmd(mkUnit(mOpen[b], CMD_PRECHARGE, BA'(b), '0, '0));
                    mOpen[b] = 1'b0;
                end
                expectCmd(mkUnit(1'b1, CMD_REFRESH, '0, '0, '0));
            end else if (i_req_valid) begin
                acceptCount++;
                rw = i_req_write ? CMD_WRITE : CMD_READ;
                if (mOpen[i_req_bank] && mRow[i_req_bank] != i_req_row)
                    expectCmd(mkUnit(1'b1, CMD_PRECHARGE, i_req_bank, '0, '0));
                if (!(mOpen[i_req_bank] && mRow[i_req_bank] == i_req_row))
                    expectCmd(mkUnit(1'b1, CMD_ACTIVE, i_req_bank, i_req_row, '0));
                expectCmd(mkUnit(1'b1, rw, i_req_bank, '0, i_req_col));
                mOpen[i_req_bank] = 1'b1;
                mRow[i_req_bank]  = i_req_row;
            end
            if (mCnt == 0) begin
                mPending = 1'b1;
                mCnt     = RI - 1;
            end else begin
                mCnt--;
            end
        end
    end

    always @(negedge clk) begin : monitorProc
        unit_t e;
        if (!rst && o_issue_wen === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedPush", 32'(o_issue_cmd), 32'(CMD_NOP));
            end else begin
                e = expQ.pop_front();
                checkOutput("cmd", 32'(o_issue_cmd), 32'(e.cmd));
                checkOutput("bank", 32'(o_issue_bank), 32'(e.bank));
                if (e.cmd == CMD_ACTIVE)
                    checkOutput("row", 32'(o_issue_row), 32'(e.row));
                if (e.cmd == CMD_READ || e.cmd == CMD_WRITE)
                    checkOutput("col", 32'(o_issue_col), 32'(e.col));
            end
        end
    end

    task automatic applyStimulus(input bit w, input int b, input int row, input int col);
        int startCount;
        bit done;
        startCount  = acceptCount;
        done        = 1'b0;
        i_req_valid = 1'b1;
        i_req_write = w;
        i_req_bank  = BA'(b);
        i_req_row   = RB'(row);
        i_req_col   = CB'(col);
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            done = (acceptCount != startCount);
        end
        #1;
        i_req_valid = 1'b0;
        if (!done) checkOutput("acceptTimeout", 32'd0, 32'd1);
    endtask

    task automatic waitModel(input int kind, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            ok = (workQ.size() == 0) && !mPending && (kind == 0 ? mCnt == 0 : mCnt > 6);
            if (!ok) begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) checkOutput(name, 32'd0, 32'd1);
    endtask

    int freeBank;

    initial begin
        rst = 1'b1;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        i_req_bank = '0;
        i_req_row = '0;
        i_req_col = '0;
        i_issue_queue_full = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rstCmd", 32'(o_issue_cmd), 32'd0);
        checkOutput("rstBank", 32'(o_issue_bank), 32'd0);
        checkOutput("rstRow", 32'(o_issue_row), 32'd0);
        checkOutput("rstCol", 32'(o_issue_col), 32'd0);
        @(posedge clk);
        #1;

        // Miss, hit, then a conflict held off by a full FIFO for 5 cycles.
        applyStimulus(1'b0, 2, 'h10, 'h4);
        applyStimulus(1'b1, 2, 'h10, 'h8);
        applyStimulus(1'b0, 2, 'h20, 'h1);
        i_issue_queue_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 i_issue_queue_full = 1'b0;

        applyStimulus(1'b0, 1, 'h30, 'h2);
        applyStimulus(1'b0, 5, 'h40, 'h3);
        repeat (45) @(posedge clk);
        #1;
        applyStimulus(1'b0, 1, 'h30, 'h5);

        // Request presented in the very cycle refresh becomes pending.
        waitModel(0, "tieSetupTimeout");
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 6, 'h11, 'h7);

        // Reset while a miss is stalled in the ACT step behind a full FIFO.
        waitModel(1, "rstSetupTimeout");
        freeBank = 0;
        for (int b = NB - 1; b >= 0; b--) if (!mOpen[b]) freeBank = b;
        i_issue_queue_full = 1'b1;
        applyStimulus(1'b0, freeBank, 'h55, 'h9);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        i_issue_queue_full = 1'b0;
        @(negedge clk);
        checkOutput("postRstWen", 32'(o_issue_wen), 32'd0);
        checkOutput("postRstCmd", 32'(o_issue_cmd), 32'd0);
        checkOutput("postRstBank", 32'(o_issue_bank), 32'd0);
        checkOutput("postRstRow", 32'(o_issue_row), 32'd0);
        checkOutput("postRstCol", 32'(o_issue_col), 32'd0);
        checkOutput("postRstBusy", 32'(o_busy), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, freeBank, 'h55, 'h9);

        for (int c = 0; c < 3000; c++) begin
            i_req_valid        = ($urandom_range(0, 99) < 60);
            i_req_write        = 1'($urandom_range(0, 1));
            i_req_bank         = BA'($urandom_range(0, NB - 1));
            i_req_row          = ($urandom_range(0, 3) == 0) ? RB'($urandom) : RB'(16 * $urandom_range(1, 3));
            i_req_col          = CB'($urandom);
            i_issue_queue_full = ($urandom_range(0, 99) < 25);
            @(posedge clk);
            #1;
        end
        i_req_valid = 1'b0;
        i_issue_queue_full = 1'b0;
        for (int i = 0; i < 200 && (expQ.size() != 0 || workQ.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        checkOutput("drainEmpty", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
